// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
// The watchdog is built only when APB_MASTER_TIMEOUT_EN is defined.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_master_state_e;

    localparam int APB_DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase watchdog for apb_master_bridge; used only with APB_MASTER_TIMEOUT_EN.
// expired_o flags the stall cycle that brings the count to TIMEOUT_CYCLES.
module apb_timeout_counter
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT      = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count <= '0;
        end else if (en_i && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired_o = en_i && (count == LIMIT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid bus to APB3 initiator bridge, one outstanding transfer.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that never see pready_i.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    apb_master_state_e state, next_state;
    logic load, respond, abort, psel_d, penable_d, expired;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (state == SETUP),
        .en_i      (state == ACCESS && !pready_i),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: defaults first so no path through the case leaves a latch behind.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_i) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (pready_i || expired) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs decoded here are the D-side of the registered APB strobes.
    always_comb begin
        gnt_o     = 1'b0;
        load      = 1'b0;
        respond   = 1'b0;
        abort     = 1'b0;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        case (state)
            IDLE: begin
                gnt_o  = req_i;
                load   = req_i;
                psel_d = req_i;
            end
            SETUP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            ACCESS: begin
                respond   = pready_i;
                abort     = !pready_i && expired;
                psel_d    = !(pready_i || expired);
                penable_d = !(pready_i || expired);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= '0;
            pwdata_o  <= '0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            psel_o    <= psel_d;
            penable_o <= penable_d;
            rvalid_o  <= respond || abort;
            if (load) begin
                paddr_o  <= addr_i;
                pwrite_o <= we_i;
                pwdata_o <= wdata_i;
            end
            if (respond) begin
                rdata_o <= pwrite_o ? '0 : prdata_i;
                err_o   <= pslverr_i;
            end else if (abort) begin
                rdata_o <= '0;
                err_o   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed table, hand sequences, random traffic.
// Timeout sequence is compiled in when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

    localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int MAX_WAITS = TO - 1;
`else
    localparam int MAX_WAITS = 5;
`endif

    logic        clk = 1'b0;
    logic        rst, req, we, pready, pslverr;
    logic [31:0] addr, wdata, prdata;
    logic        gnt, rvalid, err, psel, penable, pwrite;
    logic [31:0] rdata, paddr, pwdata;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_master_bridge #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .addr_i    (addr),
        .we_i      (we),
        .wdata_i   (wdata),
        .gnt_o     (gnt),
        .rvalid_o  (rvalid),
        .rdata_o   (rdata),
        .err_o     (err),
        .psel_o    (psel),
        .penable_o (penable),
        .pwrite_o  (pwrite),
        .paddr_o   (paddr),
        .pwdata_o  (pwdata),
        .prdata_i  (prdata),
        .pready_i  (pready),
        .pslverr_i (pslverr)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          gnt_cyc;
    } resp_t;

    resp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: response content and latency from the transfer description alone.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_rdata = v.we ? 32'h0 : v.prdata;
        r.exp_err   = v.slverr;
        r.exp_lat   = 3 + v.waits;
        return r;
    endfunction

    task automatic check_resp();
        resp_t r;
        check("rvalid", rvalid, 1);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            r = sb.pop_front();
            check("rdata", rdata, r.rdata);
            check("err", err, r.err);
            check("latency", cyc - r.gnt_cyc, r.lat);
        end
    endtask

    task automatic check_apb(input vec_t v, input logic en);
        check("psel", psel, 1);
        check("penable", penable, en);
        check("paddr", paddr, v.addr);
        check("pwrite", pwrite, v.we);
        check("pwdata", pwdata, v.wdata);
        check("gnt_busy", gnt, 0);
        check("rvalid_busy", rvalid, 0);
    endtask

    // Runs C0 (grant) through the last ACCESS cycle; returns positioned at the response cycle.
    task automatic do_xfer(input vec_t v, input bit have_prev, input bit hold, input vec_t nv);
        req     = 1'b1;
        we      = v.we;
        addr    = v.addr;
        wdata   = v.wdata;
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
        #1;
        check("gnt", gnt, 1);
        if (have_prev) check_resp();
        else           check("rvalid_idle", rvalid, 0);
        sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat, cyc});
        next_cycle();
        req = hold;
        if (hold) begin
            we = nv.we; addr = nv.addr; wdata = nv.wdata;
        end else begin
            we = 1'($urandom); addr = $urandom; wdata = $urandom;
        end
        pready = 1'($urandom);
        #1;
        check_apb(v, 0);
        next_cycle();
        for (int i = 0; i <= v.waits; i++) begin
            pready  = (i == v.waits);
            pslverr = (i == v.waits) ? v.slverr : 1'($urandom);
            prdata  = (i == v.waits) ? v.prdata : $urandom;
            #1;
            check_apb(v, 1);
            next_cycle();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    task automatic finish_resp();
        req    = 1'b0;
        pready = 1'($urandom);
        #1;
        check_resp();
        next_cycle();
    endtask

    task automatic idle_cycle();
        req    = 1'b0;
        addr   = $urandom;
        pready = 1'($urandom);
        #1;
        check("psel_idle", psel, 0);
        check("penable_idle", penable, 0);
        check("gnt_idle", gnt, 0);
        check("rvalid_idle", rvalid, 0);
        next_cycle();
    endtask

    vec_t tbl[4];
    vec_t rv[60];
    bit   chain[60];
    vec_t dummy, a, b;
    int   g1;
    bit   have_prev;

    initial begin
        // Directed vectors with hand-derived expected responses.
        tbl[0] = '{1'b0, 32'h1A10_0004, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3};
        tbl[1] = '{1'b1, 32'h1A10_0008, 32'h1234_5678, 32'hCAFE_F00D, 3, 1'b0, 32'h0000_0000, 1'b0, 6};
        tbl[2] = '{1'b0, 32'h1A10_000C, 32'h0000_0000, 32'h0BAD_0BAD, 0, 1'b1, 32'h0BAD_0BAD, 1'b1, 3};
        tbl[3] = '{1'b1, 32'h1A10_0010, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1, 1'b1, 32'h0000_0000, 1'b1, 4};
        dummy  = tbl[0];

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        @(negedge clk);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        next_cycle();

        for (int i = 0; i < 4; i++) begin
            do_xfer(tbl[i], 0, 0, dummy);
            finish_resp();
            idle_cycle();
        end

        // Back-to-back: second grant in the first response cycle.
        a = model('{1'b1, 32'h1A10_0020, 32'h0F0F_0F0F, 32'h0, 0, 1'b0, 32'h0, 1'b0, 0});
        b = model('{1'b0, 32'h1A10_0024, 32'h0, 32'h7766_5544, 0, 1'b1, 32'h0, 1'b0, 0});
        g1 = cyc;
        do_xfer(a, 0, 1, b);
        do_xfer(b, 1, 0, dummy);
        req = 1'b0;
        #1;
        check("b2b_span", cyc - g1, 6);
        check_resp();
        next_cycle();

        // Reset while in ACCESS, with pready also high: reset must win.
        req = 1'b1; we = 1'b0; addr = 32'h1A10_0030; wdata = 32'h1;
        #1;
        check("rst_seq_gnt", gnt, 1);
        next_cycle();
        req = 1'b0;
        #1;
        check("rst_seq_setup_psel", psel, 1);
        next_cycle();
        pready = 1'b1; prdata = 32'h5555_AAAA; rst = 1'b1;
        #1;
        check("rst_seq_penable", penable, 1);
        next_cycle();
        rst = 1'b0; pready = 1'b0;
        #1;
        check("rst_mid_psel", psel, 0);
        check("rst_mid_penable", penable, 0);
        check("rst_mid_paddr", paddr, 0);
        check("rst_mid_pwdata", pwdata, 0);
        check("rst_mid_pwrite", pwrite, 0);
        check("rst_mid_rvalid", rvalid, 0);
        check("rst_mid_rdata", rdata, 0);
        check("rst_mid_err", err, 0);
        next_cycle();
        idle_cycle();

`ifdef APB_MASTER_TIMEOUT_EN
        // Watchdog: four stalled ACCESS cycles, then an error response; late pready ignored.
        req = 1'b1; we = 1'b0; addr = 32'h1A10_0040; wdata = 32'h0;
        #1;
        check("to_gnt", gnt, 1);
        next_cycle();
        req = 1'b0;
        next_cycle();
        for (int i = 0; i < TO; i++) begin
            pready = 1'b0; prdata = $urandom;
            #1;
            check("to_psel", psel, 1);
            check("to_penable", penable, 1);
            next_cycle();
        end
        pready = 1'b1; prdata = 32'h1111_2222;
        #1;
        check("to_psel_drop", psel, 0);
        check("to_penable_drop", penable, 0);
        check("to_rvalid", rvalid, 1);
        check("to_err", err, 1);
        check("to_rdata", rdata, 0);
        next_cycle();
        #1;
        check("to_late_rvalid", rvalid, 0);
        check("to_late_psel", psel, 0);
        next_cycle();
        pready = 1'b0;
        idle_cycle();
`endif

        // Random traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            vec_t v;
            v.we     = 1'($urandom);
            v.addr   = $urandom;
            v.wdata  = $urandom;
            v.prdata = $urandom;
            v.waits  = int'($urandom_range(MAX_WAITS, 0));
            v.slverr = ($urandom_range(3, 0) == 0);
            rv[n]    = model(v);
            chain[n] = (n != 59) && 1'($urandom);
        end
        have_prev = 0;
        for (int n = 0; n < 60; n++) begin
            do_xfer(rv[n], have_prev, chain[n], (n < 59) ? rv[n+1] : dummy);
            if (chain[n]) begin
                have_prev = 1;
            end else begin
                have_prev = 0;
                finish_resp();
                for (int g = 0; g < int'($urandom_range(2, 0)); g++) idle_cycle();
            end
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Bridge from the core-side request/grant/rvalid bus to a single APB3 initiator port. It sits upstream of `apb_node`: the bridge generates `psel`/`penable` phases, and `apb_node` decodes `paddr` and fans the transfer out to peripherals. It holds one outstanding transfer, sequences APB SETUP/ACCESS phases, waits on `pready`, and returns read data and error status. An optional watchdog aborts transfers that never complete.

## Interface
Reset is synchronous and active-high. All logic is clocked on the rising edge of `clk_i`.

Parameters:
- `APB_ADDR_WIDTH`, 32, width of the address (`addr_i`, `paddr_o`).
- `APB_DATA_WIDTH`, 32, width of the data paths (`wdata_i`, `rdata_o`, `pwdata_o`, `prdata_i`).
- `TIMEOUT_CYCLES`, 256, ACCESS-phase cycle limit; used only with `APB_MASTER_TIMEOUT_EN`; legal range ≥1.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  synchronous reset, active-high
- `req_i`  in  1  core transfer request
- `addr_i`  in  APB_ADDR_WIDTH  request address
- `we_i`  in  1  1 = write, 0 = read
- `wdata_i`  in  APB_DATA_WIDTH  write data
- `gnt_o`  out  1  request accepted this cycle
- `rvalid_o`  out  1  response valid, one-cycle pulse
- `rdata_o`  out  APB_DATA_WIDTH  read data; 0 for writes
- `err_o`  out  1  response error (`pslverr` or timeout)
- `psel_o`  out  1  APB select
- `penable_o`  out  1  APB enable
- `pwrite_o`  out  1  APB direction
- `paddr_o`  out  APB_ADDR_WIDTH  APB address
- `pwdata_o`  out  APB_DATA_WIDTH  APB write data
- `prdata_i`  in  APB_DATA_WIDTH  APB read data
- `pready_i`  in  1  APB ready
- `pslverr_i`  in  1  APB slave error

## Operation
The state machine has three states: IDLE, SETUP and ACCESS.

- **IDLE**
  - `gnt_o = req_i`, combinational.
  - On `req_i`, latch `addr_i`, `we_i` and `wdata_i` into the `paddr_o`, `pwrite_o` and `pwdata_o` registers, then go to SETUP.
- **SETUP**
  - `psel_o = 1`, `penable_o = 0`.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - `psel_o = 1`, `penable_o = 1`.
  - If `pready_i` = 0, stay in ACCESS.
  - If `pready_i` = 1, register the response for the next cycle: `rvalid_o = 1`, `err_o = pslverr_i`, `rdata_o = we ? 0 : prdata_i`. Then go to IDLE.
- **Output rules**
  - `paddr_o`, `pwrite_o` and `pwdata_o` are stable from SETUP through the end of ACCESS.
  - They keep their last value while in IDLE.
- **Response outputs**
  - `rdata_o` and `err_o` hold their value until the next response.
  - They are meaningful only while `rvalid_o` = 1.
- **Input sampling**
  - `pslverr_i` and `prdata_i` are sampled only in ACCESS with `pready_i` = 1.
  - `pready_i` outside ACCESS is ignored.
- **Request rules**
  - `gnt_o` is 0 in SETUP and ACCESS.
  - The requester holds `req_i` and its payload until granted.
- **Reset values**
  - All outputs reset to 0: `psel_o`, `penable_o`, `pwrite_o`, `paddr_o`, `pwdata_o`, `rvalid_o`, `rdata_o`, `err_o`.
  - State resets to IDLE.
- **Reset mid-transfer**
  - `psel_o` and `penable_o` drop on the reset edge.
  - No `rvalid_o` is produced for the aborted transfer.

## Timing
- Cycle numbering for a zero-wait transfer:
  - C0: grant.
  - C1: SETUP.
  - C2: ACCESS, with `pready_i` = 1.
  - C3: `rvalid_o` = 1.
- Each wait cycle extends ACCESS, and therefore delays `rvalid_o`, by one cycle.
- Back-to-back transfers:
  - A new request can be granted in the same cycle as `rvalid_o` (C3).
  - Its SETUP is C4.
  - Maximum throughput is one transfer per 3 cycles.
- `gnt_o` has a combinational path from `req_i`. All APB outputs are registered.

## Configuration
The feature is selected by the macro `APB_MASTER_TIMEOUT_EN`.

- **Defined**
  - A counter clears on entering ACCESS and increments on each ACCESS cycle with `pready_i` = 0.
  - When the count reaches `TIMEOUT_CYCLES` and `pready_i` = 0, the transfer aborts:
    - go to IDLE and drop `psel_o`/`penable_o` next cycle;
    - next cycle `rvalid_o` = 1, `err_o` = 1, `rdata_o` = 0.
  - If `pready_i` = 1 arrives in that same cycle, it wins and the normal response is returned.
  - A `pready_i` arriving after the abort is ignored.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- **Undefined**
  - No counter is present.
  - ACCESS waits indefinitely for `pready_i`.

## Structure
- Package `apb_pkg` contains:
  - the state enum typedef `apb_master_state_e` with values IDLE, SETUP, ACCESS;
  - the constant `APB_DEFAULT_TIMEOUT` = 256.
- Sub-module `apb_timeout_counter`:
  - Ports: `clk_i`, `rst_i`, `clr_i`, `en_i`, `expired_o`; parameter `TIMEOUT_CYCLES`.
  - Instantiated only under `APB_MASTER_TIMEOUT_EN`.

## Test plan
- **Zero-wait read:** `req_i`, `addr_i` = 0x1A10_0004, `we_i` = 0, slave `pready_i` = 1 in ACCESS with `prdata_i` = 0xDEAD_BEEF.
  - `gnt_o` in C0; `psel_o` in C1–C2; `penable_o` in C2 only.
  - C3: `rvalid_o` = 1, `rdata_o` = 0xDEAD_BEEF, `err_o` = 0.
- **Write with 3 wait states:** `wdata_i` = 0x1234_5678.
  - `paddr_o`/`pwdata_o` stable for 5 APB cycles.
  - `rvalid_o` in C6, `rdata_o` = 0.
- **Slave error:** `pslverr_i` = 1 with `pready_i` = 1 → `err_o` = 1 with `rvalid_o`.
- **Back-to-back:** `req_i` held high for 2 transfers.
  - Second `gnt_o` coincides with the first `rvalid_o`.
  - 6 cycles from first grant to second `rvalid_o`.
- **Timeout (macro on, `TIMEOUT_CYCLES` = 4):** `pready_i` held at 0.
  - `rvalid_o` = 1, `err_o` = 1, `rdata_o` = 0 after 4 ACCESS cycles.
  - A late `pready_i` produces no second response.
- **Reset in ACCESS:** `rst_i` asserted in C2 → next cycle all outputs 0 and state IDLE; no `rvalid_o`.
